// File: rtl/fetch_stall_unit.sv
// Purpose : instruction-fetch stage; owns the PC, issues NOP bubbles while stalled and replays the held instruction.
// Latency : pm_addr is the PC register (combinational); ins_out is registered one cycle after its address.
// Backpres: stall freezes the PC and issues bubbles; stall_pm on release selects the held instruction over pm_data.
module fetch_stall_unit #(
    parameter int                 PC_W    = 16,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = '0,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               stall_pm,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic [PC_W-1:0]    pm_addr,
    output logic [INSTR_W-1:0] ins_out,
    output logic               ins_valid,
    output logic [1:0]         state_out,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               jump_pend_q, jump_pend_d;
    logic [PC_W-1:0]    jump_tgt_q, jump_tgt_d;

    logic [INSTR_W-1:0] ins_out_q, ins_out_d;
    logic               ins_valid_q, ins_valid_d;
    logic [INSTR_W-1:0] ins_hold_q, ins_hold_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

    // Set whenever this cycle puts a NOP on ins_out; drives the bubble counter.
    logic               bubble_issue;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any stall parks in BUBBLE; leaving BUBBLE replays only
    // when memory data is invalid and no redirect is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BUBBLE: begin
                if (stall) begin
                    state_d = ST_BUBBLE;
                end else if (jump_pend_q) begin
                    state_d = ST_RUN;
                end else if (stall_pm) begin
                    state_d = ST_REPLAY;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // RUN and REPLAY behave identically; REPLAY just lasts one cycle.
            default: begin
                state_d = stall ? ST_BUBBLE : ST_RUN;
            end
        endcase
    end

    // FSM outputs: select what goes to decode and when the held copy is taken.
    always_comb begin
        ins_out_d    = ins_out_q;
        ins_valid_d  = ins_valid_q;
        ins_hold_d   = ins_hold_q;
        bubble_issue = 1'b0;
        case (state_q)
            ST_BUBBLE: begin
                if (stall || jump_pend_q) begin
                    // Still stalled, or exiting towards a redirect: the held
                    // instruction is stale and must not reach decode.
                    ins_out_d    = NOP;
                    ins_valid_d  = 1'b0;
                    bubble_issue = 1'b1;
                end else if (stall_pm) begin
                    ins_out_d   = ins_hold_q;
                    ins_valid_d = 1'b1;
                end else begin
                    ins_out_d   = pm_data;
                    ins_valid_d = 1'b1;
                end
            end
            default: begin
                if (stall) begin
                    // Entering a stall: keep the word memory is showing now,
                    // since it may be gone by the time the stall releases.
                    ins_hold_d   = pm_data;
                    ins_out_d    = NOP;
                    ins_valid_d  = 1'b0;
                    bubble_issue = 1'b1;
                end else begin
                    ins_out_d   = pm_data;
                    ins_valid_d = 1'b1;
                end
            end
        endcase
    end

    // Saturating bubble counter: sticks at all-ones instead of wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_issue && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // PC / redirect: stall freezes PC and banks the latest jump; a fresh jump
    // beats a banked one; otherwise step sequentially with natural wrap.
    always_comb begin
        pc_d        = pc_q;
        jump_pend_d = jump_pend_q;
        jump_tgt_d  = jump_tgt_q;
        if (stall) begin
            if (jump_en) begin
                jump_pend_d = 1'b1;
                jump_tgt_d  = jump_addr;
            end
        end else if (jump_en) begin
            pc_d        = jump_addr;
            jump_pend_d = 1'b0;
        end else if (jump_pend_q) begin
            pc_d        = jump_tgt_q;
            jump_pend_d = 1'b0;
        end else begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // Datapath registers; reset also drops any banked redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            jump_pend_q  <= 1'b0;
            jump_tgt_q   <= '0;
            ins_out_q    <= NOP;
            ins_valid_q  <= 1'b0;
            ins_hold_q   <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            jump_pend_q  <= jump_pend_d;
            jump_tgt_q   <= jump_tgt_d;
            ins_out_q    <= ins_out_d;
            ins_valid_q  <= ins_valid_d;
            ins_hold_q   <= ins_hold_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pm_addr    = pc_q;
    assign ins_out    = ins_out_q;
    assign ins_valid  = ins_valid_q;
    assign state_out  = state_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Purpose : self-checking bench for fetch_stall_unit against a behavioural fetch model.
// Latency : every cycle compares all outputs 1 time unit after the rising edge.
// Backpres: stalls, releases and redirects are driven directed and randomized.
module tb_fetch_stall_unit;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 8;
    localparam logic [31:0] NOP_W = 32'h0000_0000;
    localparam int CNT_MAX = 255;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               stall_pm;
    logic               jump_en;
    logic [PC_W-1:0]    jump_addr;
    logic [INSTR_W-1:0] pm_data;
    logic [PC_W-1:0]    pm_addr;
    logic [INSTR_W-1:0] ins_out;
    logic               ins_valid;
    logic [1:0]         state_out;
    logic [CNT_W-1:0]   bubble_cnt;

    int n_checks;
    int n_fail;

    // Behavioural model state: stage mode 0=run,1=stalled(bubble),2=replayed.
    logic [15:0] m_pc;
    logic [15:0] m_tgt;
    bit          m_pend;
    logic [31:0] m_hold;
    logic [31:0] m_out;
    bit          m_valid;
    int          m_mode;
    int          m_cnt;

    fetch_stall_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .NOP     ('0),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .stall_pm   (stall_pm),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pm_data    (pm_data),
        .pm_addr    (pm_addr),
        .ins_out    (ins_out),
        .ins_valid  (ins_valid),
        .state_out  (state_out),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Combinational program memory.
    assign pm_data = mem_word(pm_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_tgt   = 16'h0000;
        m_pend  = 1'b0;
        m_hold  = 32'h0;
        m_out   = NOP_W;
        m_valid = 1'b0;
        m_mode  = 0;
        m_cnt   = 0;
    endtask

    task automatic bubble();
        m_out   = NOP_W;
        m_valid = 1'b0;
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    // One clock of fetch behaviour computed from the pre-edge model state.
    task automatic model_step(input bit s, input bit spm, input bit je, input logic [15:0] ja);
        logic [31:0] cur;
        cur = mem_word(m_pc);
        if (s) begin
            if (m_mode != 1) m_hold = cur;
            bubble();
            m_mode = 1;
        end else if (m_mode == 1 && m_pend) begin
            bubble();
            m_mode = 0;
        end else if (m_mode == 1 && spm) begin
            m_out   = m_hold;
            m_valid = 1'b1;
            m_mode  = 2;
        end else begin
            m_out   = cur;
            m_valid = 1'b1;
            m_mode  = 0;
        end
        if (s) begin
            if (je) begin
                m_pend = 1'b1;
                m_tgt  = ja;
            end
        end else if (je) begin
            m_pc   = ja;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc   = m_tgt;
            m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".pm_addr"},    32'(pm_addr),    32'(m_pc));
        chk({ctx, ".ins_out"},    ins_out,         m_out);
        chk({ctx, ".ins_valid"},  32'(ins_valid),  32'(m_valid));
        chk({ctx, ".state"},      32'(state_out),  32'(m_mode));
        chk({ctx, ".bubble_cnt"}, 32'(bubble_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle (called 1 time unit after a rising edge), then check.
    task automatic cyc(input string ctx, input bit s, input bit spm, input bit je, input logic [15:0] ja);
        stall     = s;
        stall_pm  = spm;
        jump_en   = je;
        jump_addr = ja;
        model_step(s, spm, je, ja);
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        stall     = 1'b0;
        stall_pm  = 1'b0;
        jump_en   = 1'b0;
        jump_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        // Free run from address 0.
        for (int i = 0; i < 5; i++) cyc("run", 0, 0, 0, 16'h0);
        chk("run.pc_at_5", 32'(pm_addr), 32'd5);

        // Two-cycle stall at PC=5, released with memory invalid -> replay.
        cyc("stall_a", 1, 0, 0, 16'h0);
        cyc("stall_a", 1, 0, 0, 16'h0);
        cyc("stall_a.rel", 0, 1, 0, 16'h0);
        chk("replay.ins_hold", ins_out, 32'h1000_0005);
        cyc("stall_a.post", 0, 0, 0, 16'h0);
        chk("replay.cnt2", 32'(bubble_cnt), 32'd2);

        // Stall released with valid memory: straight back to run.
        cyc("stall_b", 1, 0, 0, 16'h0);
        cyc("stall_b.rel", 0, 0, 0, 16'h0);
        // stall_pm while running is ignored.
        cyc("run_pm", 0, 1, 0, 16'h0);

        // Redirect to 9, then a jump arriving mid-stall is deferred.
        cyc("jmp9", 0, 0, 1, 16'h0009);
        cyc("jstall", 1, 0, 1, 16'h0040);
        cyc("jstall", 1, 1, 0, 16'h0000);
        cyc("jstall", 1, 0, 0, 16'h0000);
        chk("jstall.pc_held", 32'(pm_addr), 32'h0009);
        cyc("jstall.rel", 0, 1, 0, 16'h0000);
        chk("jstall.pc_tgt", 32'(pm_addr), 32'h0040);
        chk("jstall.nop", 32'(ins_valid), 32'd0);
        cyc("jstall.post", 0, 0, 0, 16'h0000);

        // Later jump during stall overwrites target; fresh jump beats pending.
        cyc("jover", 1, 0, 1, 16'h0100);
        cyc("jover", 1, 0, 1, 16'h0200);
        cyc("jover.rel", 0, 0, 0, 16'h0);
        chk("jover.pc", 32'(pm_addr), 32'h0200);
        cyc("jfresh", 1, 0, 1, 16'h0300);
        cyc("jfresh.rel", 0, 1, 1, 16'h0444);
        chk("jfresh.pc", 32'(pm_addr), 32'h0444);

        // PC wrap at the top of the address space.
        cyc("wrap", 0, 0, 1, 16'hFFFE);
        cyc("wrap", 0, 0, 0, 16'h0);
        chk("wrap.ffff", 32'(pm_addr), 32'h0000_FFFF);
        cyc("wrap", 0, 0, 0, 16'h0);
        chk("wrap.zero", 32'(pm_addr), 32'h0000_0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          s;
            bit          spm;
            bit          je;
            logic [15:0] ja;
            s   = ($urandom_range(0, 99) < 35);
            spm = 1'($urandom_range(0, 1));
            je  = ($urandom_range(0, 99) < 12);
            ja  = 16'($urandom);
            cyc("rand", s, spm, je, ja);
        end

        // Reset asserted mid-bubble with a redirect pending.
        cyc("rstj", 1, 0, 1, 16'h0777);
        cyc("rstj", 1, 0, 0, 16'h0000);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("rstj.async");
        stall = 1'b0;
        stall_pm = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all("rstj.held");
        cyc("rstj.after", 0, 1, 0, 16'h0);
        cyc("rstj.after", 0, 1, 0, 16'h0);
        chk("rstj.no_jump", 32'(pm_addr), 32'd2);

        // Long stall: bubble counter saturates.
        for (int i = 0; i < 300; i++) cyc("sat", 1, 0, 0, 16'h0);
        chk("sat.cnt", 32'(bubble_cnt), 32'd255);
        cyc("sat.rel", 0, 0, 0, 16'h0);
        cyc("sat.run", 0, 0, 0, 16'h0);
        chk("sat.hold", 32'(bubble_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
